// File: rtl/result_sram_reader.sv
// result_sram_reader: sequential read-back engine for the result data SRAM.
// Issues a run of reads from base_addr, then streams the returned words out
// over valid/ready through a small prefetch FIFO. A read is only issued when
// the FIFO is guaranteed to have room for its data, so backpressure never
// drops a word.
module result_sram_reader #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 13,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   count,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   issue_left;
    logic [ADDR_W:0]   send_left;
    logic              pending;

    logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W-1:0]  fifo_count_nxt;
    logic [CNT_W:0]    credit_used;
    logic              can_issue;
    logic              push;
    logic              pop;

    assign push      = pending;
    assign pop       = out_valid && out_ready;
    assign out_valid = (fifo_count != '0);
    assign out_data  = fifo_mem[rd_ptr];

    // Occupancy after this cycle's push/pop, and whether a read issued for
    // next cycle still has a guaranteed FIFO slot (occupancy + in-flight read).
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        fifo_count_nxt = fifo_count;
        case ({push, pop})
            2'b10:   fifo_count_nxt = fifo_count + CNT_W'(1);
            2'b01:   fifo_count_nxt = fifo_count - CNT_W'(1);
            default: fifo_count_nxt = fifo_count;
        endcase
        credit_used = {1'b0, fifo_count_nxt} + {{CNT_W{1'b0}}, mem_rd};
        can_issue   = credit_used < (CNT_W + 1)'(FIFO_DEPTH);
    end

    // Transfer control: latches the request, issues reads, tracks words owed
    // downstream and produces busy/done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            addr        <= '0;
            issue_left  <= '0;
            send_left   <= '0;
            mem_rd      <= 1'b0;
            mem_address <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            // NOTE: state uses non-blocking assignments so every register
            // sees the pre-edge values of the others, whatever the order.
            done <= 1'b0;
            if (pop) begin
                send_left <= send_left - (ADDR_W + 1)'(1);
            end
            case (state)
                IDLE: begin
                    mem_rd <= 1'b0;
                    if (start) begin
                        if (count != '0) begin
                            // First read goes out immediately: FIFO is empty.
                            mem_rd      <= 1'b1;
                            mem_address <= base_addr;
                            addr        <= base_addr + ADDR_W'(1);
                            issue_left  <= count - (ADDR_W + 1)'(1);
                            send_left   <= count;
                            busy        <= 1'b1;
                            state       <= READ;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (issue_left != '0 && can_issue) begin
                        mem_rd      <= 1'b1;
                        mem_address <= addr;
                        addr        <= addr + ADDR_W'(1);
                        issue_left  <= issue_left - (ADDR_W + 1)'(1);
                    end else begin
                        mem_rd <= 1'b0;
                    end
                    if (issue_left == '0) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    mem_rd <= 1'b0;
                    if (pop && send_left == (ADDR_W + 1)'(1)) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    mem_rd <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    // Prefetch FIFO: captures SRAM return data one cycle after each read and
    // presents the oldest word as the stream head.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the storage is reset too (it is tiny) so out_data reads 0
            // out of reset; an in-flight return is dropped by clearing pending.
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            pending    <= 1'b0;
        end else begin
            pending <= mem_rd;
            if (push) begin
                fifo_mem[wr_ptr] <= mem_rd_data;
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            fifo_count <= fifo_count_nxt;
        end
    end

endmodule

// File: tb/tb_result_sram_reader.sv
// Testbench for result_sram_reader: an SRAM model answers reads, and a
// scoreboard derived from (base, count) predicts the address sequence, the
// returned words, the read credit limit, busy and the done pulse.
module tb_result_sram_reader;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 13;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [ADDR_W:0]   count = '0;
    logic [ADDR_W-1:0] mem_address;
    logic              mem_rd;
    logic [DATA_W-1:0] mem_rd_data = '0;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic              busy;
    logic              done;

    result_sram_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .base_addr   (base_addr),
        .count       (count),
        .mem_address (mem_address),
        .mem_rd      (mem_rd),
        .mem_rd_data (mem_rd_data),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_bad    = 0;
    int cyc      = 0;
    int ready_mode = 0;   // 0: always ready, 1: 1,0,0,1 pattern, 2: random

    logic [DATA_W-1:0] sram [0:(1<<ADDR_W)-1];

    // scoreboard state
    logic [DATA_W-1:0] exp_q [$];
    logic [ADDR_W-1:0] exp_addr;
    int  xfer_len = 0;
    int  issued   = 0;
    int  popped   = 0;
    bit  model_busy = 1'b0;
    bit  exp_done   = 1'b0;
    bit  prev_stall = 1'b0;
    logic [DATA_W-1:0] prev_data;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // SRAM with one-cycle registered read
    always @(posedge clk) begin
        if (mem_rd) mem_rd_data <= sram[mem_address];
    end

    // downstream ready generator
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // mid-cycle monitor and scoreboard
    always @(negedge clk) begin
        bit busy_now;
        bit done_now;
        logic [DATA_W-1:0] w;
        logic [ADDR_W-1:0] a;
        if (rst) begin
            exp_q.delete();
            model_busy = 1'b0;
            exp_done   = 1'b0;
            prev_stall = 1'b0;
            issued     = 0;
            popped     = 0;
            xfer_len   = 0;
        end else begin
            busy_now = model_busy;
            done_now = exp_done;
            exp_done = 1'b0;
            check("busy", busy, busy_now);
            if (done || done_now) check("done", done, done_now);
            if (mem_rd) begin
                check("rd_in_xfer", busy_now && (issued < xfer_len), 1);
                check("rd_addr", mem_address, exp_addr);
                check("credit", (issued - popped) < DEPTH, 1);
                exp_addr++;
                issued++;
            end
            if (prev_stall) begin
                check("stall_valid", out_valid, 1);
                check("stall_data", out_data, prev_data);
            end
            if (out_valid && out_ready) begin
                check("word_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    w = exp_q.pop_front();
                    check("word", out_data, w);
                    popped++;
                    if (popped == xfer_len) begin
                        exp_done   = 1'b1;
                        model_busy = 1'b0;
                    end
                end
            end
            if (start && !busy_now) begin
                if (count == '0) begin
                    exp_done = 1'b1;
                end else begin
                    model_busy = 1'b1;
                    xfer_len   = int'(count);
                    issued     = 0;
                    popped     = 0;
                    exp_addr   = base_addr;
                    exp_q.delete();
                    a = base_addr;
                    for (int i = 0; i < xfer_len; i++) begin
                        exp_q.push_back(sram[a]);
                        a++;
                    end
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
    end

    task automatic start_xfer(input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] c);
        @(posedge clk);
        #1;
        base_addr = b;
        count     = c;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_mem_rd"}, mem_rd, 0);
        check({tag, "_mem_addr"}, mem_address, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_data"}, out_data, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
    endtask

    initial begin
        bit ok;
        int c3;
        logic [ADDR_W-1:0] b;
        logic [ADDR_W:0]   c;

        for (int i = 0; i < (1 << ADDR_W); i++) sram[i] = DATA_W'(i + 'h100);

        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        rst = 1'b0;

        // basic transfer with exact latency and throughput
        ready_mode = 0;
        start_xfer(16'h0010, 17'd5);
        check("lat_mem_rd", mem_rd, 1);
        check("lat_addr", mem_address, 16'h0010);
        check("lat_busy", busy, 1);
        @(posedge clk); #1;
        check("lat_no_valid_n2", out_valid, 0);
        @(posedge clk); #1;
        check("lat_valid_n3", out_valid, 1);
        check("lat_first_word", out_data, 13'h110);
        c3 = cyc;
        wait_done(50, ok);
        check("basic_done_seen", ok, 1);
        check("basic_done_cycle", cyc - c3, 5);
        check("basic_busy_with_done", busy, 0);

        // backpressure
        ready_mode = 1;
        start_xfer(16'h0200, 17'd8);
        wait_done(200, ok);
        check("bp_done_seen", ok, 1);
        check("bp_all_words", popped, 8);

        // wrap-around
        ready_mode = 0;
        start_xfer(16'hFFFE, 17'd4);
        wait_done(50, ok);
        check("wrap_done_seen", ok, 1);
        check("wrap_all_words", popped, 4);

        // zero count
        start_xfer(16'h1234, 17'd0);
        check("zero_done", done, 1);
        check("zero_busy", busy, 0);
        check("zero_mem_rd", mem_rd, 0);
        check("zero_valid", out_valid, 0);
        @(posedge clk); #1;
        check("zero_done_once", done, 0);
        check("zero_valid_later", out_valid, 0);

        // start while busy is ignored
        ready_mode = 1;
        start_xfer(16'h0300, 17'd6);
        repeat (2) @(posedge clk);
        #1;
        base_addr = 16'h5555;
        count     = 17'd3;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(200, ok);
        check("busy_start_done_seen", ok, 1);
        check("busy_start_words", popped, 6);
        check("busy_start_q_empty", exp_q.size(), 0);

        // reset mid-transfer
        ready_mode = 0;
        start_xfer(16'h0400, 17'd10);
        for (int i = 0; i < 100 && popped < 3; i++) begin
            @(posedge clk); #1;
        end
        check("rst_reached_3", popped, 3);
        rst = 1'b1;
        #1;
        check_outputs_zero("midrst");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        start_xfer(16'h0700, 17'd4);
        wait_done(50, ok);
        check("post_rst_done_seen", ok, 1);
        check("post_rst_words", popped, 4);

        // randomized transfers on random memory contents
        for (int i = 0; i < (1 << ADDR_W); i++) sram[i] = DATA_W'($urandom);
        ready_mode = 2;
        for (int t = 0; t < 25; t++) begin
            b = ($urandom_range(0, 3) == 0) ? ADDR_W'(16'hFFF0 + $urandom_range(0, 15))
                                            : ADDR_W'($urandom);
            c = (ADDR_W + 1)'($urandom_range(1, 24));
            repeat ($urandom_range(0, 3)) @(posedge clk);
            start_xfer(b, c);
            wait_done(400, ok);
            check("rand_done_seen", ok, 1);
            check("rand_words", popped, int'(c));
        end

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule

// File: doc/result_sram_reader.md
Name: result_sram_reader

Overview:
- Read-back engine for the 13-bit result data SRAM.
- The control path writes results into that SRAM. This block is the reader on the other end of the same single-port interface.
- On start, it issues sequential reads from base_addr for count words.
- It streams the returned words out over a valid/ready handshake, buffered by a small prefetch FIFO so backpressure never drops data.

Parameters:
- ADDR_W, 16, SRAM address width; addresses wrap modulo 2^ADDR_W.
- DATA_W, 13, SRAM word width.
- FIFO_DEPTH, 4, prefetch FIFO entries; minimum 2; must be a power of 2.

Ports:
- clk  input  1  clock, all state on posedge.
- rst  input  1  asynchronous active-high reset.
- start  input  1  begin transfer; sampled only in IDLE.
- base_addr  input  ADDR_W  first address; latched on accepted start.
- count  input  ADDR_W+1  words to read, 0..2^ADDR_W; latched on accepted start.
- mem_address  output  ADDR_W  SRAM address, registered.
- mem_rd  output  1  SRAM read strobe.
- mem_rd_data  input  DATA_W  SRAM registered read data, valid the cycle after mem_rd.
- out_data  output  DATA_W  stream data (FIFO head).
- out_valid  output  1  stream data valid.
- out_ready  input  1  downstream accept.
- busy  output  1  high from accepted start until done.
- done  output  1  one-cycle pulse when the last word is accepted downstream.

Behaviour:
- Reset (async, rst=1):
  - mem_rd=0, mem_address=0, out_valid=0, out_data=0, busy=0, done=0.
  - FIFO is emptied, the pending flag is cleared, and the state goes to IDLE.
  - Reset mid-transfer abandons the transfer with no done pulse. The SRAM return in flight is discarded.
- States: IDLE, READ, DRAIN.
- IDLE:
  - start=1 and count>0: latch addr=base_addr, issue_left=count, send_left=count; busy=1; go to READ.
  - start=1 and count=0: done=1 next cycle; busy stays 0; stay in IDLE.
- READ:
  - Issue rule: mem_rd=1 in a cycle iff issue_left>0 and fifo_count+pending<FIFO_DEPTH. pending is 1 if mem_rd was high the previous cycle.
  - On each issue: mem_address=addr, then addr increments with wrap (0xFFFF -> 0x0000) and issue_left decrements.
  - When issue_left reaches 0: go to DRAIN.
- Data return: when pending=1, mem_rd_data is pushed into the FIFO at the end of that cycle. The credit rule guarantees the FIFO never overflows.
- Stream:
  - out_valid = FIFO non-empty; out_data = FIFO head.
  - A transfer occurs when out_valid and out_ready are both high; that pops the FIFO and decrements send_left.
  - While out_valid=1 and out_ready=0, out_data must hold stable.
  - Push and pop may occur in the same cycle; fifo_count is unchanged.
- DRAIN: when the transfer taking send_left from 1 to 0 occurs, done=1 the next cycle, busy=0, and the state returns to IDLE.
- Latency:
  - start high in cycle N: mem_rd=1 with address=base in N+1, data returns in N+2, out_valid=1 in N+3.
  - With out_ready held high, throughput is 1 word/cycle (FIFO_DEPTH>=4).
- start while busy: ignored; latched values are unchanged.
- count=2^ADDR_W: reads the full memory, starting at base_addr and wrapping through to base_addr-1.
- mem_rd is never asserted outside READ.

Test Plan:
- Basic transfer: SRAM preloaded with addr+0x100; base=0x0010, count=5, out_ready=1 -> out_data 0x110..0x114 in order, one per cycle from N+3; done pulses once; busy falls with done.
- Backpressure: count=8, out_ready toggling 1,0,0,1,... -> all 8 words delivered in order, none dropped or duplicated; out_data stable while stalled; mem_rd never asserted while fifo_count+pending=4.
- Wrap-around: base=0xFFFE, count=4 -> addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001; data matches the preload.
- Zero count: start with count=0 -> no mem_rd, out_valid stays 0, done=1 one cycle after start, busy stays 0.
- start while busy: second start with different base/count mid-transfer -> ignored; the original 6-word transfer completes unchanged.
- Reset mid-operation: rst pulsed after 3 of 10 words -> all outputs 0 immediately, FIFO empty, no done pulse; a fresh start afterwards reads correctly from its own base.
